// File: rtl/tetris_stat_ctrl.sv
// Post-lock statistics sequencer and gravity timer: scans the full-row mask,
// strobes the stat block with the cleared-line count, then retunes the drop period.
module tetris_stat_ctrl #(
  parameter int ROWS        = 20,
  parameter int BASE_PERIOD = 25_000_000,
  parameter int STEP_PERIOD = 2_000_000,
  parameter int MIN_PERIOD  = 2_500_000,
  parameter int LVL_LATENCY = 2
) (
  input  logic            clk_i,
  input  logic            srst_i,
  input  logic            new_game_i,
  input  logic            game_over_i,
  input  logic            pause_i,
  input  logic            lock_i,
  input  logic [ROWS-1:0] full_rows_i,
  input  logic [7:0]      level_i,
  output logic [2:0]      disappear_lines_cnt_o,
  output logic            update_stat_en_o,
  output logic            stat_srst_o,
  output logic            busy_o,
  output logic            drop_tick_o,
  output logic            game_active_o
);

  // state    | meaning
  // IDLE     | gravity running, waiting for a lock
  // SCAN     | shifting the captured row mask, counting full rows
  // UPDATE   | one-cycle stat update strobe
  // WAIT_LVL | letting the stat block settle its level output
  // RELOAD   | recompute drop period from the new level
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SCAN     = 3'd1;
  localparam logic [2:0] S_UPDATE   = 3'd2;
  localparam logic [2:0] S_WAIT_LVL = 3'd3;
  localparam logic [2:0] S_RELOAD   = 3'd4;

  localparam int CW     = $clog2((BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD : MIN_PERIOD) + 1;
  localparam int RW     = $clog2(ROWS + 1);
  localparam int LW     = $clog2(LVL_LATENCY + 1);
  localparam int DW_RAW = $clog2(99 * STEP_PERIOD + 1);
  localparam int DW     = (DW_RAW > CW) ? DW_RAW : CW;

  localparam logic [DW-1:0] BASE_DW = DW'(BASE_PERIOD);
  localparam logic [DW-1:0] SPAN_DW = DW'(BASE_PERIOD - MIN_PERIOD);
  localparam logic [DW-1:0] STEP_DW = DW'(STEP_PERIOD);

  logic [2:0]      state;
  logic [ROWS-1:0] rows_sr;
  logic [RW-1:0]   scan_cnt;
  logic [LW-1:0]   wait_cnt;
  logic [2:0]      line_cnt;
  logic [2:0]      line_cnt_nxt;
  logic [CW-1:0]   period;
  logic [CW-1:0]   drop_cnt;
  logic            game_active;
  logic            drop_tick;
  logic            stat_srst;

  logic [7:0]      lvl_raw;
  logic [7:0]      lvl_bin;
  logic [DW-1:0]   drop_dec;
  logic [CW-1:0]   reload_period;
  logic            run;
  logic            tc;

  assign line_cnt_nxt = (line_cnt == 3'd4) ? 3'd4 : line_cnt + {2'b00, rows_sr[0]};

  // Out-of-range BCD digits are clamped so the decrement product never exceeds its width.
  assign lvl_raw  = ({4'b0000, level_i[7:4]} * 8'd10) + {4'b0000, level_i[3:0]};
  assign lvl_bin  = (lvl_raw > 8'd99) ? 8'd99 : lvl_raw;
  assign drop_dec = DW'(lvl_bin - 8'd1) * STEP_DW;

  always_comb begin
    reload_period = CW'(BASE_PERIOD);
    if (lvl_bin <= 8'd1) begin
      reload_period = CW'(BASE_PERIOD);
    end else if (drop_dec >= SPAN_DW) begin
      reload_period = CW'(MIN_PERIOD);
    end else begin
      reload_period = CW'(BASE_DW - drop_dec);
    end
  end

  assign run = (state == S_IDLE) && game_active && !pause_i;
  assign tc  = (drop_cnt == (period - CW'(1)));

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state    <= S_IDLE;
      rows_sr  <= '0;
      scan_cnt <= '0;
      wait_cnt <= '0;
      line_cnt <= 3'd0;
    end else if (new_game_i) begin
      state    <= S_IDLE;
      line_cnt <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (lock_i) begin
            rows_sr  <= full_rows_i;
            scan_cnt <= RW'(ROWS - 1);
            line_cnt <= 3'd0;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          rows_sr  <= rows_sr >> 1;
          line_cnt <= line_cnt_nxt;
          if (scan_cnt == '0) begin
            state <= (line_cnt_nxt == 3'd0) ? S_IDLE : S_UPDATE;
          end else begin
            scan_cnt <= scan_cnt - RW'(1);
          end
        end
        S_UPDATE: begin
          wait_cnt <= LW'(LVL_LATENCY - 1);
          state    <= S_WAIT_LVL;
        end
        S_WAIT_LVL: begin
          if (wait_cnt == '0) begin
            state <= S_RELOAD;
          end else begin
            wait_cnt <= wait_cnt - LW'(1);
          end
        end
        S_RELOAD: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Gravity: a lock landing on the terminal count swallows that tick and holds the count.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      period      <= CW'(BASE_PERIOD);
      drop_cnt    <= '0;
      game_active <= 1'b0;
      drop_tick   <= 1'b0;
      stat_srst   <= 1'b0;
    end else if (new_game_i) begin
      period      <= CW'(BASE_PERIOD);
      drop_cnt    <= '0;
      game_active <= 1'b1;
      drop_tick   <= 1'b0;
      stat_srst   <= 1'b1;
    end else begin
      stat_srst <= 1'b0;
      drop_tick <= 1'b0;
      if (game_over_i) begin
        game_active <= 1'b0;
      end
      if (state == S_RELOAD) begin
        period   <= reload_period;
        drop_cnt <= '0;
      end else if (run) begin
        if (tc) begin
          if (!lock_i) begin
            drop_tick <= 1'b1;
            drop_cnt  <= '0;
          end
        end else begin
          drop_cnt <= drop_cnt + CW'(1);
        end
      end
    end
  end

  assign busy_o                = (state != S_IDLE);
  assign update_stat_en_o      = (state == S_UPDATE);
  assign disappear_lines_cnt_o = ((state == S_UPDATE) || (state == S_WAIT_LVL)) ? line_cnt : 3'd0;
  assign stat_srst_o           = stat_srst;
  assign drop_tick_o           = drop_tick;
  assign game_active_o         = game_active;

endmodule
